// File: rtl/key_conditioner.sv
// key_conditioner: per-channel pushbutton synchronizer, debouncer and edge
// pulse generator for active-low KEY inputs.
// Optional build macro KEY_AUTOREPEAT_EN adds auto-repeat KEY_PRESS pulses
// while a key stays held; without it each accepted press pulses exactly once.
module key_conditioner #(
  parameter int unsigned NKEYS           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [NKEYS-1:0] KEY,
  output logic [NKEYS-1:0] KEY_LEVEL,
  output logic [NKEYS-1:0] KEY_PRESS,
  output logic [NKEYS-1:0] KEY_RELEASE
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NKEYS-1:0] s1_q, s1_d;
  logic [NKEYS-1:0] sync_q, sync_d;
  logic [NKEYS-1:0] level_q, level_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [NKEYS-1:0] release_q, release_d;
  state_t           state_q [NKEYS];
  state_t           state_d [NKEYS];
  logic [CNT_W-1:0] cnt_q   [NKEYS];
  logic [CNT_W-1:0] cnt_d   [NKEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q   [NKEYS];
  logic [RPT_W-1:0] rpt_d   [NKEYS];
  logic [NKEYS-1:0] first_q, first_d;
`else
  // Repeat timing has no effect in this build; the parameters stay for interface compatibility.
  if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_repeat_unused
  end
`endif

  // Next-state and pulse decode for every channel FSM plus synchronizer shift.
  always_comb begin
    s1_d      = KEY;
    sync_d    = s1_q;
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d     = rpt_q;
    first_d   = '1;
`endif
    for (int k = 0; k < NKEYS; k++) begin
`ifdef KEY_AUTOREPEAT_EN
      // Timer is held cleared outside HELD so any departure cancels it.
      rpt_d[k] = '0;
`endif
      case (state_q[k])
        IDLE: begin
          if (!sync_q[k]) begin
            state_d[k] = PRESS_WAIT;
            cnt_d[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync_q[k]) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
            press_d[k] = 1'b1;
          end else if (cnt_q[k] != CNT_MAX) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        HELD: begin
          if (sync_q[k]) begin
            state_d[k] = RELEASE_WAIT;
            cnt_d[k]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rpt_q[k] == (first_q[k] ? DELAY_LAST : PERIOD_LAST)) begin
            press_d[k] = 1'b1;
            rpt_d[k]   = '0;
            first_d[k] = 1'b0;
          end else begin
            rpt_d[k]   = rpt_q[k] + RPT_W'(1);
            first_d[k] = first_q[k];
          end
`endif
        end
        RELEASE_WAIT: begin
          if (!sync_q[k]) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            release_d[k] = 1'b1;
          end else if (cnt_q[k] != CNT_MAX) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
        end
      endcase
      level_d[k] = (state_d[k] == HELD) || (state_d[k] == RELEASE_WAIT);
    end
  end

  // State, synchronizer and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1_q      <= '1;
      sync_q    <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q[k]   <= '0;
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      first_q   <= '1;
`endif
    end else begin
      s1_q      <= s1_d;
      sync_q    <= sync_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
      first_q   <= first_d;
`endif
    end
  end

  assign KEY_LEVEL   = level_q;
  assign KEY_PRESS   = press_q;
  assign KEY_RELEASE = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: vector table, directed corner
// sequences and random KEY activity against a run-length reference model.
module tb_key_conditioner;

  localparam int unsigned NK = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b0;
  logic [NK-1:0] KEY      = '1;
  logic [NK-1:0] KEY_LEVEL;
  logic [NK-1:0] KEY_PRESS;
  logic [NK-1:0] KEY_RELEASE;

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
    .KEY_LEVEL(KEY_LEVEL), .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: a new level is accepted once D+1 consecutive
  // synchronized samples disagree with the debounced level.
  logic [NK-1:0] m_s1 = '1, m_sync = '1, m_lvl = '0, m_prs = '0, m_rel = '0;
  int m_run [NK];
  int m_age [NK];
  bit m_first [NK];

  int n_press [NK];
  int n_rel [NK];
  int last_press [NK];
  int last_rel [NK];
  int first_press [NK];
  bit lvl_hi0 = 1'b0;

  task automatic chk(string name, logic [NK-1:0] act, logic [NK-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit pressed;
    int prev_run;
    cyc++;
    if (!RESET_N) begin
      m_s1 = '1; m_sync = '1; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] = 0; m_age[k] = 0; m_first[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        pressed  = !m_sync[k];
        prev_run = m_run[k];
        m_prs[k] = 1'b0;
        m_rel[k] = 1'b0;
        if (pressed != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = pressed;
            m_run[k] = 0;
            if (pressed) begin
              m_prs[k] = 1'b1; m_age[k] = 0; m_first[k] = 1'b1;
            end else begin
              m_rel[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
          if (AUTOREP && m_lvl[k]) begin
            if (prev_run > 0) begin
              m_age[k] = 0; m_first[k] = 1'b1;
            end else begin
              m_age[k]++;
              if (m_age[k] == (m_first[k] ? RD : RP)) begin
                m_prs[k] = 1'b1; m_age[k] = 0; m_first[k] = 1'b0;
              end
            end
          end
        end
      end
      m_sync = m_s1;
      m_s1   = KEY;
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    model_step();
  end

  // Compare against the model and log pulses on every falling edge.
  initial begin
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0; n_rel[k] = 0; last_press[k] = -1; last_rel[k] = -1; first_press[k] = -1;
    end
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        chk("model_level", KEY_LEVEL, m_lvl);
        chk("model_press", KEY_PRESS, m_prs);
        chk("model_release", KEY_RELEASE, m_rel);
        chk("press_release_exclusive", KEY_PRESS & KEY_RELEASE, {NK{1'b0}});
      end
      if (KEY_LEVEL[0] === 1'b1) lvl_hi0 = 1'b1;
      for (int k = 0; k < NK; k++) begin
        if (KEY_PRESS[k] === 1'b1) begin
          n_press[k]++; last_press[k] = cyc;
          if (first_press[k] < 0) first_press[k] = cyc;
        end
        if (KEY_RELEASE[k] === 1'b1) begin
          n_rel[k]++; last_rel[k] = cyc;
        end
      end
    end
  end

  typedef struct {
    logic          rst_n;
    logic [NK-1:0] key;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(int n, logic r, logic [NK-1:0] k, logic [NK-1:0] l,
                     logic [NK-1:0] p, logic [NK-1:0] e);
    vec_t v;
    v.rst_n = r; v.key = k; v.lvl = l; v.prs = p; v.rel = e;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    int c, pb, rb, exp_cnt, t;
    int rate;

    // Each row is driven at a falling edge and checked one clock later;
    // a pulse lands 7 edges after the edge that first samples the new KEY.
    add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
    add(6, 1'b1, 3'b110, 3'b000, 3'b000, 3'b000);
    add(1, 1'b1, 3'b110, 3'b001, 3'b001, 3'b000);
    add(2, 1'b1, 3'b110, 3'b001, 3'b000, 3'b000);
    add(6, 1'b1, 3'b111, 3'b001, 3'b000, 3'b000);
    add(1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b001);
    add(1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
    add(6, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, 1'b1, 3'b000, 3'b111, 3'b111, 3'b000);
    add(1, 1'b1, 3'b000, 3'b111, 3'b000, 3'b000);
    add(6, 1'b1, 3'b111, 3'b111, 3'b000, 3'b000);
    add(1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b111);
    add(1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);

    @(negedge CLOCK_50);
    for (int i = 0; i < vecs.size(); i++) begin
      RESET_N = vecs[i].rst_n;
      KEY     = vecs[i].key;
      @(negedge CLOCK_50);
      chk($sformatf("vec%0d_level", i), KEY_LEVEL, vecs[i].lvl);
      chk($sformatf("vec%0d_press", i), KEY_PRESS, vecs[i].prs);
      chk($sformatf("vec%0d_release", i), KEY_RELEASE, vecs[i].rel);
      chk_en = 1'b1;
    end

    // Bounce every 2 cycles must never be accepted.
    KEY = '1; tick(10);
    pb = n_press[0]; lvl_hi0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      KEY[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    KEY = '1; tick(10);
    chk_int("bounce_press_count", n_press[0] - pb, 0);
    chk_int("bounce_level_seen", int'(lvl_hi0), 0);

    // Press, then release with a 3-cycle bounce.
    c = cyc; KEY = 3'b110; tick(8);
    chk_int("press_latency", last_press[0], c + 7);
    pb = n_press[0]; rb = n_rel[0];
    KEY[0] = 1'b1; tick(1);
    KEY[0] = 1'b0; tick(1);
    KEY[0] = 1'b1; c = cyc; tick(12);
    chk_int("bounced_release_count", n_rel[0] - rb, 1);
    chk_int("bounced_release_latency", last_rel[0], c + 7);
    chk_int("bounced_release_no_press", n_press[0] - pb, 0);

    // Key held through reset is re-debounced and pulses again.
    KEY = 3'b110; tick(15);
    RESET_N = 1'b0; tick(1);
    chk("reset_level", KEY_LEVEL, 3'b000);
    chk("reset_press", KEY_PRESS, 3'b000);
    chk("reset_release", KEY_RELEASE, 3'b000);
    tick(1);
    chk("reset2_level", KEY_LEVEL, 3'b000);
    RESET_N = 1'b1; c = cyc; first_press[0] = -1; tick(10);
    chk_int("post_reset_press", first_press[0], c + 7);
    chk("post_reset_level", KEY_LEVEL, 3'b001);

    // Reset in mid-debounce discards the partial count.
    KEY = '1; tick(12);
    KEY = 3'b101; tick(4);
    RESET_N = 1'b0; tick(1);
    RESET_N = 1'b1; c = cyc; first_press[1] = -1; tick(10);
    chk_int("mid_debounce_reset_press", first_press[1], c + 7);

    // Long hold: auto-repeat pulses only when the feature is built in.
    KEY = '1; tick(12);
    pb = n_press[0]; c = cyc; KEY = 3'b110; tick(37);
    exp_cnt = 1;
    if (AUTOREP) begin
      t = RD;
      while (t <= 30) begin exp_cnt++; t += RP; end
    end
    chk_int("long_hold_press_count", n_press[0] - pb, exp_cnt);
    KEY = '1; tick(12);

    // Random activity, fast bouncing first, then long holds.
    for (int i = 0; i < 1200; i++) begin
      rate = (i < 500) ? 5 : 25;
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, rate) == 0) KEY[k] = ~KEY[k];
      RESET_N = ($urandom_range(0, 199) != 0);
      tick(1);
    end

    KEY = '1; RESET_N = 1'b1; tick(12);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
